// File: rtl/mem_responder.sv
// Byte-addressed RAM responder: latches one request, waits LATENCY cycles, then pulses ack.
// Latency: ack in the (LATENCY+1)-th cycle after accept; req is ignored while busy (WAIT/RESP).
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int       DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_q;
  logic [31:0] rd_data;
  logic        req_err;

  logic [7:0]  mem [DEPTH];

  logic [ADDR_W-1:0] a0, a1, a2, a3;

  assign a0 = lat_addr[ADDR_W-1:0];
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

  always_comb begin
    req_err = 1'b0;
    case (lat_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = lat_addr[0];
      2'b10:   req_err = (lat_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if ((lat_addr >> ADDR_W) != 32'd0)
      req_err = 1'b1;
  end

  // Storage is read in the RESP cycle, so a write committed by the previous transaction is visible.
  always_comb begin
    rd_data = 32'd0;
    if (!req_err) begin
      case (lat_size)
        2'b00:   rd_data = {24'd0, mem[a0]};
        2'b01:   rd_data = {16'd0, mem[a1], mem[a0]};
        2'b10:   rd_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
        default: rd_data = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    ack       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT;
          end
        end
      end
      WAIT: begin
        busy    = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1)
          state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign err   = ack & req_err;
  assign rdata = ack ? rd_data : rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == RESP)
        rdata_q <= rd_data;
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && req) begin
      lat_wr    <= wr;
      lat_size  <= size;
      lat_addr  <= addr;
      lat_wdata <= wdata;
    end
  end

  // Write commits on the edge that ends RESP; a reset on that edge aborts it.
  always_ff @(posedge clock) begin
    if (!reset && state == RESP && lat_wr && !req_err) begin
      case (lat_size)
        2'b00: mem[a0] <= lat_wdata[7:0];
        2'b01: begin
          mem[a0] <= lat_wdata[7:0];
          mem[a1] <= lat_wdata[15:8];
        end
        2'b10: begin
          mem[a0] <= lat_wdata[7:0];
          mem[a1] <= lat_wdata[15:8];
          mem[a2] <= lat_wdata[23:16];
          mem[a3] <= lat_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=2 instance for function, LATENCY=0 instance for throughput.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, ack, err;
  logic [31:0] rdata;

  logic        req0, wr0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0;
  logic        busy0, ack0, err0;
  logic [31:0] rdata0;

  typedef struct {
    logic        e;
    logic [31:0] d;
    logic        cd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   acks     = 0;

  always #5 clock = ~clock;

  mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req(req), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .busy(busy), .ack(ack), .rdata(rdata), .err(err)
  );

  mem_responder #(.ADDR_W(8), .LATENCY(0)) dut0 (
    .clock(clock), .reset(reset), .req(req0), .wr(wr0), .size(size0),
    .addr(addr0), .wdata(wdata0), .busy(busy0), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  always @(negedge clock) begin
    if (ack) begin
      acks++;
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("err", 32'(err), 32'(e.e));
        if (e.cd) check("rdata", rdata, e.d);
      end
    end
  end

  // One request pulse; inputs are scrambled after accept to show only the latched copy matters.
  task automatic txn(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                     input logic e, input logic [31:0] rd, input logic cd);
    int n;
    bit got;
    sb.push_back('{e, rd, cd});
    @(posedge clock); #1;
    req = 1'b1; wr = w; size = s; addr = a; wdata = d;
    @(posedge clock); #1;
    req = 1'b0; wr = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clock);
      n++;
      if (ack) got = 1'b1;
    end
    check("latency", 32'(n), 32'(LAT + 1));
  endtask

  initial begin
    int a_before;
    int n_ack0;
    reset = 1'b1;
    req = 1'b0; wr = 1'b0; size = 2'b00; addr = 32'd0; wdata = 32'd0;
    req0 = 1'b0; wr0 = 1'b0; size0 = 2'b00; addr0 = 32'd0; wdata0 = 32'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);

    // word write / read-back, then rdata holds after ack
    txn(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
    txn(1'b0, 2'b10, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 1'b1);
    repeat (3) @(negedge clock);
    check("rdata_hold", rdata, 32'hDEADBEEF);

    // sub-word
    txn(1'b1, 2'b00, 32'h11, 32'h00000055, 1'b0, 32'd0, 1'b0);
    txn(1'b0, 2'b10, 32'h10, 32'd0, 1'b0, 32'hDEAD55EF, 1'b1);
    txn(1'b0, 2'b01, 32'h12, 32'd0, 1'b0, 32'h0000DEAD, 1'b1);
    txn(1'b0, 2'b00, 32'h13, 32'd0, 1'b0, 32'h000000DE, 1'b1);

    // misalignment and illegal size
    txn(1'b0, 2'b10, 32'h12, 32'd0, 1'b1, 32'd0, 1'b1);
    txn(1'b1, 2'b01, 32'h13, 32'h0000FFFF, 1'b1, 32'd0, 1'b1);
    txn(1'b0, 2'b10, 32'h10, 32'd0, 1'b0, 32'hDEAD55EF, 1'b1);
    txn(1'b0, 2'b11, 32'h10, 32'd0, 1'b1, 32'd0, 1'b1);

    // range check
    txn(1'b1, 2'b00, 32'h00, 32'h000000A5, 1'b0, 32'd0, 1'b0);
    txn(1'b1, 2'b00, 32'h100, 32'h00000077, 1'b1, 32'd0, 1'b1);
    txn(1'b0, 2'b00, 32'h00, 32'd0, 1'b0, 32'h000000A5, 1'b1);

    // reset during WAIT aborts the write
    txn(1'b1, 2'b10, 32'h20, 32'h11111111, 1'b0, 32'd0, 1'b0);
    @(posedge clock); #1;
    req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h22222222;
    @(posedge clock); #1;
    req = 1'b0;
    reset = 1'b1;
    a_before = acks;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("abort_no_ack", 32'(acks - a_before), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    txn(1'b0, 2'b10, 32'h20, 32'd0, 1'b0, 32'h11111111, 1'b1);

    // zero latency, req held high: ack/busy alternate
    @(posedge clock); #1;
    req0 = 1'b1; wr0 = 1'b0; size0 = 2'b00; addr0 = 32'h04;
    @(posedge clock);
    n_ack0 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check($sformatf("z_ack%0d", i), 32'(ack0), 32'((i % 2) == 0));
      check($sformatf("z_busy%0d", i), 32'(busy0), 32'((i % 2) == 0));
      if (ack0) begin
        n_ack0++;
        check("z_err", 32'(err0), 32'd0);
        check("z_rdata", rdata0, 32'd0);
      end
    end
    req0 = 1'b0;
    check("z_ack_count", 32'(n_ack0), 32'd4);
    repeat (3) @(negedge clock);
    check("z_idle_after", 32'(busy0), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's data/instruction memory interface; the CPU (initiator) drives req/wr/size/addr/wdata and waits for ack.
- Models a byte-addressed RAM with a configurable number of wait states.
- Supports byte, halfword and word accesses, and reports alignment, size and range errors.
- Used to exercise the multicycle control unit's wait handling, and as the target for load/store-size logic.

Parameters:
ADDR_W, 8, byte-address bits; storage depth = 2^ADDR_W bytes
LATENCY, 2, wait cycles inserted between request accept and ack; legal range 0..15

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  1  request valid; sampled only in IDLE
wr  input  1  1 = write, 0 = read
size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
addr  input  32  byte address
wdata  input  32  write data, right-aligned (byte in [7:0], half in [15:0])
busy  output  1  high in WAIT and RESP
ack  output  1  one-cycle completion pulse
rdata  output  32  read data, zero-extended, valid while ack=1, held until next ack
err  output  1  valid with ack; 1 = request rejected

Behaviour:
- Reset (sync, high): state=IDLE, wait counter=0, busy=0, ack=0, err=0, rdata=0. Storage contents are NOT cleared by reset; initial contents are 0 at time zero.
- Reset mid-operation: the transaction is aborted. No ack is issued and no write is performed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at a rising edge (the accept edge), latch wr/size/addr/wdata into internal registers.
  - If LATENCY>0, go to WAIT with counter=LATENCY. Otherwise go to RESP.
  - If req=0, stay in IDLE.
- WAIT: decrement counter each cycle; when counter=1, next state is RESP. Input changes during WAIT are ignored, because only the latched copy is used.
- RESP:
  - ack=1 for exactly this cycle, with err and rdata valid.
  - A write is committed at the edge ending RESP, only if err=0.
  - Next state is always IDLE. req is ignored during RESP.
- Timing:
  - ack is high in the (LATENCY+1)-th cycle after the accept edge.
  - If req is held high, the minimum spacing between acks is LATENCY+2 cycles, because one IDLE cycle always separates transactions.
- Byte ordering is little-endian: the byte at addr maps to data[7:0], and addr+1 maps to [15:8], and so on.
- Read:
  - Byte returns mem[a] in rdata[7:0], with upper bits 0.
  - Half returns {mem[a+1],mem[a]} in [15:0].
  - Word returns {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
  - Sign extension is not done here; it belongs to the CPU load path.
- Write: byte writes wdata[7:0]; half writes wdata[15:0] to a, a+1; word writes all 4 bytes. Bytes not addressed are untouched.
- Errors (err=1, rdata=0, no write) when any of the following holds:
  - size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=00.
  - addr[31:ADDR_W] nonzero.
- Read data is computed from storage at the RESP cycle. A write to the same address committed by the previous transaction is visible.
- busy=0 only in IDLE. ack is never high in two consecutive cycles.

Test Plan:
1. Word write and read-back: reset, LATENCY=2. Word write 0x10 with data 0xDEADBEEF → ack exactly 3 cycles after the accept edge, err=0. Word read of 0x10 → rdata=0xDEADBEEF.
2. Sub-word accesses: after scenario 1, byte write 0x11 with data 0x55. Then word read 0x10 → 0xDEAD55EF. Half read 0x12 → 0x0000DEAD. Byte read 0x13 → 0x000000DE.
3. Misalignment and illegal size:
   - Word read at 0x12 → ack, err=1, rdata=0.
   - Half write at 0x13 with data 0xFFFF → err=1; a subsequent word read of 0x10 is unchanged.
   - size=11 → err=1.
4. Range check: with ADDR_W=8, a byte write to 0x100 → err=1, and mem[0x00] is unchanged.
5. Reset mid-operation: word 0x20 holds 0x11111111. Start a word write to 0x20 with data 0x22222222, and assert reset during WAIT → no ack. The following read of 0x20 → 0x11111111.
6. Zero latency and throughput: LATENCY=0, req held high for 8 cycles → ack in the cycle after each accept, with acks every 2nd cycle (4 acks). busy pattern 1,0,1,0…, and no double accept during RESP.
